// File: rtl/fft16_seq_ctrl_if.sv
// fft16_seq_ctrl_if: openMSP430 peripheral bus bundle for the FFT sequencer
interface fft16_seq_ctrl_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  modport master(output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave(input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/fft16_seq_ctrl.sv
// fft16_seq_ctrl: 16-sample bank that sequences a shared radix-4 butterfly through a 2-stage in-place FFT
module fft16_seq_ctrl #(
  parameter logic [13:0] BASE_ADDR = 14'h0088,
  parameter int          DW        = 16,
  parameter int          BFLY_LAT  = 1
) (
  input  logic            mclk,
  input  logic            puc_rst,
  fft16_seq_ctrl_if.slave bus,
  output logic [DW-1:0]   bf_a_re_o, bf_a_im_o, bf_b_re_o, bf_b_im_o,
  output logic [DW-1:0]   bf_c_re_o, bf_c_im_o, bf_d_re_o, bf_d_im_o,
  output logic            bf_valid_o,
  output logic            tw_en_o,
  output logic [1:0]      tw_grp_o,
  input  logic [DW-1:0]   bf_0_re_i, bf_0_im_i, bf_1_re_i, bf_1_im_i,
  input  logic [DW-1:0]   bf_2_re_i, bf_2_im_i, bf_3_re_i, bf_3_im_i,
  output logic            irq_o
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE, S_FIN} state_t;
  localparam logic [2:0] LAST_W = 3'(BFLY_LAT > 0 ? BFLY_LAT - 1 : 0);
  state_t        r_state, w_next;
  logic [DW-1:0] r_re [16];
  logic [DW-1:0] r_im [16];
  logic [3:0]    r_idx;
  logic          r_nat, r_ie, r_done, r_stage;
  logic [1:0]    r_grp;
  logic [2:0]    r_wcnt;
  logic          w_wr, w_rd, w_ctrl, w_index, w_dre, w_dim, w_busy, w_start, w_act;
  logic [3:0]    w_p;
  logic [3:0]    w_leg [4];
  logic [DW-1:0] w_in_re [4];
  logic [DW-1:0] w_in_im [4];
  assign w_wr    = bus.per_en && bus.per_we != 2'b00;
  assign w_rd    = bus.per_en && bus.per_we == 2'b00;
  assign w_ctrl  = bus.per_en && bus.per_addr == BASE_ADDR;
  assign w_index = bus.per_en && bus.per_addr == BASE_ADDR + 14'd1;
  assign w_dre   = bus.per_en && bus.per_addr == BASE_ADDR + 14'd2;
  assign w_dim   = bus.per_en && bus.per_addr == BASE_ADDR + 14'd3;
  assign w_busy  = r_state != S_IDLE;
  assign w_start = w_ctrl && w_wr && bus.per_din[0] && !w_busy;
  assign w_act   = r_state == S_LOAD || r_state == S_WAIT || r_state == S_STORE;
  assign w_p     = r_nat ? {r_idx[1:0], r_idx[3:2]} : r_idx;
  assign w_in_re = '{bf_0_re_i, bf_1_re_i, bf_2_re_i, bf_3_re_i};
  assign w_in_im = '{bf_0_im_i, bf_1_im_i, bf_2_im_i, bf_3_im_i};
  assign bus.per_dout = !w_rd   ? 16'd0 :
                        w_ctrl  ? {11'd0, r_ie, r_nat, r_done, w_busy, 1'b0} :
                        w_index ? {12'd0, r_idx} :
                        w_dre   ? 16'(r_re[w_p]) :
                        w_dim   ? 16'(r_im[w_p]) : 16'd0;
  // stage 0 strides by 4 (g+4m), stage 1 walks contiguous quads (4g+m)
  always_comb
    for (int m = 0; m < 4; m++)
      w_leg[m] = r_stage ? {r_grp, 2'(m)} : {2'(m), r_grp};
  always_ff @(posedge mclk)
    r_state <= puc_rst ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = BFLY_LAT == 0 ? S_STORE : S_WAIT;
      S_WAIT:  w_next = r_wcnt == LAST_W ? S_STORE : S_WAIT;
      S_STORE: w_next = (r_stage && r_grp == 2'd3) ? S_FIN : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    bf_valid_o = r_state == S_LOAD;
    tw_en_o    = w_act && !r_stage;
    tw_grp_o   = w_act ? r_grp : 2'd0;
    bf_a_re_o  = w_act ? r_re[w_leg[0]] : '0;
    bf_a_im_o  = w_act ? r_im[w_leg[0]] : '0;
    bf_b_re_o  = w_act ? r_re[w_leg[1]] : '0;
    bf_b_im_o  = w_act ? r_im[w_leg[1]] : '0;
    bf_c_re_o  = w_act ? r_re[w_leg[2]] : '0;
    bf_c_im_o  = w_act ? r_im[w_leg[2]] : '0;
    bf_d_re_o  = w_act ? r_re[w_leg[3]] : '0;
    bf_d_im_o  = w_act ? r_im[w_leg[3]] : '0;
    irq_o      = r_done && r_ie;
  end
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      for (int i = 0; i < 16; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
      r_idx   <= '0;
      r_nat   <= 1'b0;
      r_ie    <= 1'b0;
      r_done  <= 1'b0;
      r_stage <= 1'b0;
      r_grp   <= 2'd0;
      r_wcnt  <= 3'd0;
    end else begin
      if (w_ctrl && w_wr) begin
        r_nat <= bus.per_din[3];
        r_ie  <= bus.per_din[4];
      end
      r_done <= w_start ? 1'b0 : r_state == S_FIN ? 1'b1 :
                (w_ctrl && w_wr && bus.per_din[2]) ? 1'b0 : r_done;
      if (w_index && w_wr)
        r_idx <= bus.per_din[3:0];
      else if (w_dim)
        r_idx <= r_idx + 4'd1;
      if (w_wr && !w_busy && w_dre)
        r_re[r_idx] <= DW'(bus.per_din);
      if (w_wr && !w_busy && w_dim)
        r_im[r_idx] <= DW'(bus.per_din);
      r_wcnt <= r_state == S_WAIT ? r_wcnt + 3'd1 : 3'd0;
      if (w_start) begin
        r_stage <= 1'b0;
        r_grp   <= 2'd0;
      end else if (r_state == S_STORE) begin
        for (int m = 0; m < 4; m++) begin
          r_re[w_leg[m]] <= w_in_re[m];
          r_im[w_leg[m]] <= w_in_im[m];
        end
        r_grp <= r_grp + 2'd1;
        if (r_grp == 2'd3)
          r_stage <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// tb_fft16_seq_ctrl: directed scoreboard bench with a configurable butterfly stub
module tb_fft16_seq_ctrl;
  localparam logic [13:0] A_CTRL = 14'h0088, A_IDX = 14'h0089, A_RE = 14'h008A, A_IM = 14'h008B;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bo_re [4];
  logic [15:0] bo_im [4];
  logic [15:0] bi_re [4];
  logic [15:0] bi_im [4];
  logic        bf_valid, tw_en, irq;
  logic [1:0]  tw_grp;
  logic        rev = 1'b0;
  logic [15:0] add = 16'd0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          bq[$];
  int          rq[$];
  logic [15:0] m_re [16];
  logic [15:0] m_im [16];
  always #5 clk = ~clk;
  fft16_seq_ctrl_if bus();
  fft16_seq_ctrl #(.BFLY_LAT(1)) dut (
    .mclk(clk), .puc_rst(rst), .bus(bus),
    .bf_a_re_o(bo_re[0]), .bf_a_im_o(bo_im[0]), .bf_b_re_o(bo_re[1]), .bf_b_im_o(bo_im[1]),
    .bf_c_re_o(bo_re[2]), .bf_c_im_o(bo_im[2]), .bf_d_re_o(bo_re[3]), .bf_d_im_o(bo_im[3]),
    .bf_valid_o(bf_valid), .tw_en_o(tw_en), .tw_grp_o(tw_grp),
    .bf_0_re_i(bi_re[0]), .bf_0_im_i(bi_im[0]), .bf_1_re_i(bi_re[1]), .bf_1_im_i(bi_im[1]),
    .bf_2_re_i(bi_re[2]), .bf_2_im_i(bi_im[2]), .bf_3_re_i(bi_re[3]), .bf_3_im_i(bi_im[3]),
    .irq_o(irq)
  );
  // stub: optional leg reversal plus a constant added to the real part
  always_comb
    for (int k = 0; k < 4; k++) begin
      bi_re[k] = bo_re[rev ? 3 - k : k] + add;
      bi_im[k] = bo_im[rev ? 3 - k : k];
    end
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic wr(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.per_en = 1'b1; bus.per_we = 2'b11; bus.per_addr = a; bus.per_din = d;
    @(posedge clk);
    #1 bus.per_en = 1'b0; bus.per_we = 2'b00;
  endtask
  task automatic rd(input logic [13:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.per_en = 1'b1; bus.per_we = 2'b00; bus.per_addr = a;
    #1 d = bus.per_dout;
    @(posedge clk);
    #1 bus.per_en = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [13:0] a, input logic [15:0] exp);
    logic [15:0] d;
    rq.push_back(int'(exp));
    rd(a, d);
    chk(tag, int'(d), rq.pop_front());
  endtask
  task automatic readout(input string tag);
    wr(A_IDX, 16'd0);
    for (int i = 0; i < 16; i++) begin
      rd_chk(tag, A_RE, m_re[i]);
      rd_chk(tag, A_IM, m_im[i]);
    end
  endtask
  // push the expected issue stream for a whole run and advance the bank model
  task automatic predict();
    logic [3:0]  ix [4];
    logic [15:0] nr [4];
    logic [15:0] ni [4];
    for (int s = 0; s < 2; s++)
      for (int g = 0; g < 4; g++) begin
        for (int m = 0; m < 4; m++) ix[m] = (s == 0) ? 4'(g + 4 * m) : 4'(4 * g + m);
        for (int m = 0; m < 4; m++) bq.push_back(int'(m_re[ix[m]]));
        for (int m = 0; m < 4; m++) bq.push_back(int'(m_im[ix[m]]));
        bq.push_back(s == 0 ? 1 : 0);
        bq.push_back(g);
        for (int k = 0; k < 4; k++) begin
          nr[k] = m_re[ix[rev ? 3 - k : k]] + add;
          ni[k] = m_im[ix[rev ? 3 - k : k]];
        end
        for (int k = 0; k < 4; k++) begin
          m_re[ix[k]] = nr[k];
          m_im[ix[k]] = ni[k];
        end
      end
  endtask
  task automatic run(input logic [15:0] sv, input int inj, input int stop_at);
    int          last = 0;
    int          done_it = -1;
    int          obs, exp;
    logic        reading;
    logic [15:0] d;
    predict();
    wr(A_CTRL, sv);
    for (int it = 1; it <= 200; it++) begin
      @(negedge clk);
      if (it == stop_at) break;
      bus.per_en = 1'b1;
      reading = 1'b0;
      if (inj != 0 && it == 5) begin
        bus.per_we = 2'b11; bus.per_addr = A_CTRL; bus.per_din = sv;
      end else if (inj != 0 && it == 6) begin
        bus.per_we = 2'b11; bus.per_addr = A_RE; bus.per_din = 16'h7FFF;
      end else begin
        bus.per_we = 2'b00; bus.per_addr = A_CTRL; reading = 1'b1;
      end
      #1 d = bus.per_dout;
      if (bf_valid) begin
        for (int j = 0; j < 10; j++) begin
          if (j < 4) obs = int'(bo_re[j]);
          else if (j < 8) obs = int'(bo_im[j - 4]);
          else if (j == 8) obs = int'(tw_en);
          else obs = int'(tw_grp);
          exp = bq.size() > 0 ? bq.pop_front() : -1;
          chk("bf_issue", obs, exp);
        end
        if (last > 0) chk("bf_gap", it - last, 3);
        else chk("first_issue", it, 1);
        last = it;
      end
      if (it == 3) chk("irq_busy", int'(irq), 0);
      @(posedge clk);
      #1 bus.per_en = 1'b0; bus.per_we = 2'b00;
      if (reading && d[2] && !d[1]) begin
        done_it = it;
        break;
      end
    end
    if (stop_at == 0) begin
      chk("busy_cycles", done_it - 1, 25);
      chk("bf_pending", bq.size(), 0);
    end
  endtask
  initial begin
    bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = '0; bus.per_din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", int'(bf_valid), 0);
    chk("rst_irq", int'(irq), 0);
    rd_chk("rst_ctrl", A_CTRL, 16'h0000);
    rd_chk("rst_index", A_IDX, 16'h0000);
    rd_chk("rst_re", A_RE, 16'h0000);
    rd_chk("rst_im", A_IM, 16'h0000);
    wr(A_CTRL, 16'h0018);
    rd_chk("ctrl_rw", A_CTRL, 16'h0018);
    wr(A_CTRL, 16'h0000);
    wr(A_IDX, 16'd14);
    for (int i = 1; i <= 5; i += 2) begin
      wr(A_RE, 16'(i));
      wr(A_IM, 16'(i + 1));
    end
    rd_chk("index_wrap", A_IDX, 16'd1);
    wr(A_IDX, 16'd14);
    for (int i = 1; i <= 5; i += 2) begin
      rd_chk("wrap_re", A_RE, 16'(i));
      rd_chk("wrap_im", A_IM, 16'(i + 1));
    end
    wr(A_IDX, 16'd0);
    for (int i = 0; i < 16; i++) begin
      m_re[i] = 16'(i);
      m_im[i] = 16'(-i);
      wr(A_RE, m_re[i]);
      wr(A_IM, m_im[i]);
    end
    rd_chk("index_after_load", A_IDX, 16'd0);
    run(16'h0001, 0, 0);
    rd_chk("ctrl_done", A_CTRL, 16'h0004);
    chk("idle_bf_zero", int'(bo_re[3]), 0);
    readout("ident_nat0");
    wr(A_CTRL, 16'h0008);
    wr(A_IDX, 16'd1);
    rd_chk("nat1_re1", A_RE, 16'd4);
    rd_chk("nat1_im1", A_IM, 16'hFFFC);
    wr(A_IDX, 16'd6);
    rd_chk("nat1_re6", A_RE, 16'd9);
    rd_chk("nat1_im6", A_IM, 16'hFFF7);
    rev = 1'b1;
    add = 16'd1;
    run(16'h0001, 0, 0);
    readout("rev_add");
    rev = 1'b0;
    add = 16'd0;
    run(16'h0011, 1, 0);
    chk("irq_done", int'(irq), 1);
    rd_chk("ctrl_done_ie", A_CTRL, 16'h0014);
    readout("busy_ignore");
    wr(A_CTRL, 16'h0014);
    rd_chk("done_clear", A_CTRL, 16'h0010);
    chk("irq_clear", int'(irq), 0);
    run(16'h0001, 0, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bq.delete();
    for (int i = 0; i < 16; i++) begin
      m_re[i] = 16'd0;
      m_im[i] = 16'd0;
    end
    chk("abort_valid", int'(bf_valid), 0);
    rd_chk("abort_ctrl", A_CTRL, 16'h0000);
    readout("abort_bank");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
